mem_port_arbiter: RTL

Two-requester arbiter and sequencer for the single load/store port of `cache_system`. It shares the cache between the integer load/store path (port 0) and the RVF `flw`/`fsw` path (port 1). Arbitration is round-robin, and the granted requester is locked to the port for the whole duration of a miss. Each requester gets its own stall, and the block keeps a saturating conflict counter for performance analysis.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter and sequencer that shares the single
//            load/store port of cache_system between the integer path
//            (port 0) and the floating-point flw/fsw path (port 1). The
//            granted requester stays locked to the port for a whole miss.
//            A saturating counter records the cycles in which both ports
//            requested.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,          // asynchronous, active low

    input  logic          re0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wd0,
    output logic [DW-1:0] rd0,
    output logic          stall0,
    output logic          done0,

    input  logic          re1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wd1,
    output logic [DW-1:0] rd1,
    output logic          stall1,
    output logic          done1,

    output logic          c_re,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wd,
    input  logic [DW-1:0] c_rd,
    input  logic          c_stall,

    output logic [CW-1:0] conflict_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          prio_q,  prio_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          req0, req1;
    logic          sel;         // port currently connected to the cache
    logic          sel_vld;     // a port is connected this cycle
    logic          grant_done;  // the connected access completes this cycle

    assign req0 = re0 | we0;
    assign req1 = re1 | we1;

    // Next-state logic: pick the connected port and decide lock/release.
    // In HOLD the selection comes only from owner_q, so c_stall never
    // reaches the address/data mux.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        sel        = 1'b0;
        sel_vld    = 1'b0;
        grant_done = 1'b0;
        case (state_q)
            IDLE: begin
                sel_vld = req0 | req1;
                sel     = (req0 & req1) ? prio_q : req1;
                if (sel_vld) begin
                    if (!c_stall) begin
                        grant_done = 1'b1;
                        prio_d     = ~sel;
                    end else begin
                        owner_d = sel;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Owner keeps the port even if it illegally drops its request.
                sel     = owner_q;
                sel_vld = 1'b1;
                if (!c_stall) begin
                    grant_done = 1'b1;
                    prio_d     = ~owner_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output steering: connected port drives the cache; everything is
    // forced to zero while reset is asserted.
    always_comb begin
        c_re   = 1'b0;
        c_we   = 1'b0;
        c_addr = '0;
        c_wd   = '0;
        rd0    = '0;
        rd1    = '0;
        done0  = 1'b0;
        done1  = 1'b0;
        stall0 = 1'b0;
        stall1 = 1'b0;
        if (reset) begin
            if (sel_vld) begin
                if (sel) begin
                    c_we   = we1;
                    c_re   = re1 & ~we1;   // read+write is treated as a write
                    c_addr = addr1;
                    c_wd   = wd1;
                    rd1    = c_rd;
                    done1  = grant_done;
                end else begin
                    c_we   = we0;
                    c_re   = re0 & ~we0;
                    c_addr = addr0;
                    c_wd   = wd0;
                    rd0    = c_rd;
                    done0  = grant_done;
                end
            end
            stall0 = req0 & ~done0;
            stall1 = req1 & ~done1;
        end
    end

    // Conflict counter: count cycles with both ports requesting, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (req0 && req1 && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire
